rr_arb_mux: RTL and testbench

- Parametrised successor to the team's gate-level 2:1 bit mux.
- Selects one of NUM_CH WIDTH-bit valid/ready channels using round-robin arbitration.
- Captures the selected word in a registered output stage and reports the winning channel index.
- Used wherever several producers share one downstream consumer, e.g. writeback-port or memory-request sharing in the RISC-V core.

---
 rtl/rr_arb_mux.sv | 106 ++++++++++
 tb/tb_rr_arb_mux.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/rr_arb_mux.sv
// Round-robin N:1 valid/ready mux with a registered output stage and winner index.
// Define RR_ARB_MUX_FIXED_PRIO_EN to replace round-robin with lowest-index-wins priority.

module rr_arb_mux_lane #(
   parameter int WIDTH = 32
) (
   input  logic             gnt,
   input  logic             load,
   input  logic [WIDTH-1:0] data,
   output logic             rdy,
   output logic [WIDTH-1:0] data_m
);
   assign rdy    = load & gnt;
   assign data_m = data & {WIDTH{gnt}};
endmodule

module rr_arb_mux #(
   parameter int WIDTH  = 32,
   parameter int NUM_CH = 4,
   localparam int SEL_W = $clog2(NUM_CH)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_CH-1:0]       in_valid,
   input  logic [NUM_CH*WIDTH-1:0] in_data,
   output logic [NUM_CH-1:0]       in_ready,
   output logic                    out_valid,
   output logic [WIDTH-1:0]        out_data,
   output logic [SEL_W-1:0]        out_ch,
   input  logic                    out_ready
);
   localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(NUM_CH - 1);

   logic                              load;
   logic                              xfer;
   logic [NUM_CH-1:0]                 grant;
   logic [SEL_W-1:0]                  gnt_idx;
   logic [SEL_W-1:0]                  base;
   logic [NUM_CH-1:0][WIDTH-1:0]      data_m;
   logic [WIDTH-1:0]                  sel_data;

   // Gating with rst_n keeps in_ready low while the output stage is held in reset.
   assign load = rst_n & (~out_valid | out_ready);
   assign xfer = load & (|grant);

`ifdef RR_ARB_MUX_FIXED_PRIO_EN
   assign base = '0;
`else
   logic [SEL_W-1:0] ptr;

   assign base = ptr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    ptr <= '0;
      else if (xfer) ptr <= (gnt_idx == LAST_CH) ? '0 : gnt_idx + 1'b1;
   end
`endif

   // Scan from base upward with wrap; first requester wins.
   always_comb begin
      logic [SEL_W-1:0] idx;
      logic             found;
      grant   = '0;
      gnt_idx = '0;
      found   = 1'b0;
      idx     = base;
      for (int k = 0; k < NUM_CH; k++) begin
         if (!found && in_valid[idx]) begin
            grant[idx] = 1'b1;
            gnt_idx    = idx;
            found      = 1'b1;
         end
         idx = (idx == LAST_CH) ? '0 : idx + 1'b1;
      end
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
      rr_arb_mux_lane #(.WIDTH(WIDTH)) u_lane (
         .gnt    (grant[i]),
         .load   (load),
         .data   (in_data[i*WIDTH +: WIDTH]),
         .rdy    (in_ready[i]),
         .data_m (data_m[i])
      );
   end

   // Grant is one-hot, so an OR of the masked lanes is the selected word.
   always_comb begin
      sel_data = '0;
      for (int i = 0; i < NUM_CH; i++) sel_data = sel_data | data_m[i];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_ch    <= '0;
      end else if (xfer) begin
         out_valid <= 1'b1;
         out_data  <= sel_data;
         out_ch    <= gnt_idx;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_rr_arb_mux.sv
// Scoreboard bench for rr_arb_mux: a queue-based arbitration model predicts every
// accepted word; a monitor pops and compares whenever the DUT presents one.

module tb_rr_arb_mux;
   localparam int WIDTH  = 8;
   localparam int NUM_CH = 4;
   localparam int SEL_W  = 2;
   localparam logic [31:0] PAT = 32'h43322110;

   typedef struct {
      logic [WIDTH-1:0] data;
      logic [SEL_W-1:0] ch;
   } exp_t;

   logic                    clk = 1'b0;
   logic                    rst_n;
   logic [NUM_CH-1:0]       in_valid;
   logic [NUM_CH*WIDTH-1:0] in_data;
   logic [NUM_CH-1:0]       in_ready;
   logic                    out_valid;
   logic [WIDTH-1:0]        out_data;
   logic [SEL_W-1:0]        out_ch;
   logic                    out_ready;

   int   n_cmp = 0;
   int   n_bad = 0;
   exp_t q[$];
   int   m_ptr = 0;
   bit   m_full = 0;
   int   pushed_now = 0;

   rr_arb_mux #(.WIDTH(WIDTH), .NUM_CH(NUM_CH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ch    (out_ch),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // One cycle of stimulus; the model decides who should win and records the expected word.
   task automatic step(input logic [NUM_CH-1:0] v, input logic r, input logic [31:0] d);
      int w;
      bit ld;
      @(negedge clk);
      #2;
      in_valid  = v;
      out_ready = r;
      in_data   = d;
      ld = !m_full || r;
      w  = -1;
      for (int k = 0; k < NUM_CH; k++) begin
         int c;
         c = (m_ptr + k) % NUM_CH;
         if (w < 0 && v[c]) w = c;
      end
      #1;
      for (int i = 0; i < NUM_CH; i++)
         chk($sformatf("in_ready[%0d]", i), 32'(in_ready[i]), 32'(ld && (i == w)));
      pushed_now = 0;
      if (ld && w >= 0) begin
         exp_t e;
         e.data = d[w*WIDTH +: WIDTH];
         e.ch   = SEL_W'(w);
         q.push_back(e);
`ifdef RR_ARB_MUX_FIXED_PRIO_EN
         m_ptr = 0;
`else
         m_ptr = (w + 1) % NUM_CH;
`endif
         m_full     = 1;
         pushed_now = 1;
      end else if (r) begin
         m_full = 0;
      end
   endtask

   // Monitor: the queue head is the word the DUT should be holding now.
   initial begin
      forever begin
         @(negedge clk);
         #4;
         if (rst_n) begin
            int held;
            held = q.size() - pushed_now;
            chk("out_valid", 32'(out_valid), 32'(held > 0));
            if (out_valid && held > 0) begin
               chk("out_data", 32'(out_data), 32'(q[0].data));
               chk("out_ch", 32'(out_ch), 32'(q[0].ch));
               if (out_ready) void'(q.pop_front());
            end
            pushed_now = 0;
         end
      end
   end

   initial begin
      rst_n     = 1'b0;
      in_valid  = '1;
      in_data   = PAT;
      out_ready = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst out_valid", 32'(out_valid), 0);
      chk("rst in_ready", 32'(in_ready), 0);
      chk("rst out_data", 32'(out_data), 0);
      chk("rst out_ch", 32'(out_ch), 0);
      in_valid = '0;
      #1 rst_n = 1'b1;

      // Rotation across all four channels, starting at ch0.
      repeat (6) step(4'b1111, 1'b1, PAT);
      // Backpressure, then resume with no bubble.
      repeat (3) step(4'b1111, 1'b0, PAT);
      repeat (2) step(4'b1111, 1'b1, PAT);
      // Sparse: only ch2 requests, wrapping past the others.
      repeat (3) step(4'b0100, 1'b1, PAT);
      // Two requesters, continuous.
      repeat (6) step(4'b1010, 1'b1, PAT);
      repeat (2) step(4'b0000, 1'b1, PAT);

      // Mid-operation reset while stalled on a held word.
      repeat (2) step(4'b1111, 1'b0, PAT);
      @(negedge clk);
      #5 rst_n = 1'b0;
      #1;
      chk("midrst out_valid", 32'(out_valid), 0);
      chk("midrst out_data", 32'(out_data), 0);
      chk("midrst in_ready", 32'(in_ready), 0);
      q.delete();
      m_full = 0;
      m_ptr  = 0;
      pushed_now = 0;
      repeat (2) @(negedge clk);
      in_valid = '0;
      #1 rst_n = 1'b1;
      repeat (2) step(4'b1111, 1'b1, PAT);

      // Randomised traffic with random backpressure.
      repeat (400) step(NUM_CH'($urandom), ($urandom_range(0, 3) != 0), $urandom);

      repeat (3) step(4'b0000, 1'b1, PAT);
      chk("queue drained", 32'(q.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
